// File: rtl/pipe_ctrl_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_chain_pkg
// Brief  : Shared control encodings for the pipeline control chain.
// Rev    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_chain_pkg;

    localparam logic [2:0] PC_NEXT      = 3'd0;
    localparam logic [2:0] PC_BRANCH    = 3'd1;
    localparam logic [2:0] PC_JUMP      = 3'd2;
    localparam logic [2:0] PC_JR        = 3'd3;

    localparam logic [1:0] WB_ADDR_RD   = 2'd0;
    localparam logic [1:0] WB_ADDR_RT   = 2'd1;
    localparam logic [1:0] WB_ADDR_LINK = 2'd2;

    localparam logic [1:0] EXE_A_RS     = 2'd0;
    localparam logic [1:0] EXE_A_LINK   = 2'd1;
    localparam logic [1:0] EXE_A_SA     = 2'd2;
    localparam logic [1:0] EXE_B_RT     = 2'd0;
    localparam logic [1:0] EXE_B_IMM    = 2'd1;
    localparam logic [1:0] EXE_B_LINK   = 2'd2;

    localparam logic [3:0] EXE_ALU_ADD  = 4'd0;
    localparam logic [3:0] EXE_ALU_SUB  = 4'd1;
    localparam logic [3:0] EXE_ALU_AND  = 4'd2;
    localparam logic [3:0] EXE_ALU_OR   = 4'd3;
    localparam logic [3:0] EXE_ALU_XOR  = 4'd4;
    localparam logic [3:0] EXE_ALU_NOR  = 4'd5;
    localparam logic [3:0] EXE_ALU_SLT  = 4'd6;
    localparam logic [3:0] EXE_ALU_SLL  = 4'd7;
    localparam logic [3:0] EXE_ALU_SRL  = 4'd8;
    localparam logic [3:0] EXE_ALU_SRA  = 4'd9;
    localparam logic [3:0] EXE_ALU_LUI  = 4'd10;

    typedef struct packed {
        logic mem_ren;
        logic mem_wen;
        logic wb_data_src;
        logic wb_wen;
    } mem_wb_ctrl_t;

    localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_chain_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_chain_stage_reg
// Brief  : One pipeline control stage: W-bit payload plus valid, rst > clr > en.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_chain_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_chain.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_chain
// Brief  : Carries the decoded ID control bundle through EXE/MEM/WB with valids.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_chain
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31,
    parameter int PC_SRC_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_rst_i,
    input  logic                if_en_i,
    input  logic                id_rst_i,
    input  logic                id_en_i,
    input  logic                exe_rst_i,
    input  logic                exe_en_i,
    input  logic                mem_rst_i,
    input  logic                mem_en_i,
    input  logic                wb_rst_i,
    input  logic                wb_en_i,
    input  logic [31:0]         inst_id_i,
    input  logic [PC_SRC_W-1:0] pc_src_i,
    input  logic [1:0]          exe_a_src_i,
    input  logic [1:0]          exe_b_src_i,
    input  logic [3:0]          exe_alu_oper_i,
    input  logic                mem_ren_i,
    input  logic                mem_wen_i,
    input  logic [1:0]          wb_addr_src_i,
    input  logic                wb_data_src_i,
    input  logic                wb_wen_i,
    output logic                if_valid_o,
    output logic                id_valid_o,
    output logic                exe_valid_o,
    output logic                mem_valid_o,
    output logic                wb_valid_o,
    output logic [PC_SRC_W-1:0] pc_src_exe_o,
    output logic [1:0]          exe_a_src_exe_o,
    output logic [1:0]          exe_b_src_exe_o,
    output logic [3:0]          exe_alu_oper_exe_o,
    output logic                is_branch_exe_o,
    output logic [REG_AW-1:0]   regw_addr_exe_o,
    output logic                wb_wen_exe_o,
    output logic                mem_ren_mem_o,
    output logic                mem_wen_mem_o,
    output logic                is_branch_mem_o,
    output logic [REG_AW-1:0]   regw_addr_mem_o,
    output logic                wb_wen_mem_o,
    output logic [REG_AW-1:0]   regw_addr_wb_o,
    output logic                wb_data_src_wb_o,
    output logic                wb_wen_wb_o
);

    localparam int EXE_W = PC_SRC_W + 8 + MEM_WB_CTRL_W + REG_AW;
    localparam int MEM_W = 1 + MEM_WB_CTRL_W + REG_AW;
    localparam int WB_W  = 2 + REG_AW;

    logic                w_unused_if_pl;
    logic                w_unused_id_pl;
    logic                w_unused_inst;
    logic [REG_AW-1:0]   w_regw_addr_id;
    mem_wb_ctrl_t        w_ctrl_id;
    logic [EXE_W-1:0]    w_exe_d;
    logic [EXE_W-1:0]    w_exe_q;
    logic                w_exe_valid;
    mem_wb_ctrl_t        w_ctrl_exe;
    logic [MEM_W-1:0]    w_mem_d;
    logic [MEM_W-1:0]    w_mem_q;
    logic                w_mem_valid;
    logic                w_is_br_mem;
    mem_wb_ctrl_t        w_ctrl_mem;
    logic [WB_W-1:0]     w_wb_d;
    logic [WB_W-1:0]     w_wb_q;
    logic                w_wb_valid;
    logic                w_if_valid;
    logic                w_id_valid;

    assign w_unused_inst = ^{inst_id_i[31:21], inst_id_i[10:0]};

    // Destination is fixed at EXE capture so later stages never see the raw selector.
    always_comb begin
        w_regw_addr_id = '0;
        case (wb_addr_src_i)
            WB_ADDR_RD:   w_regw_addr_id = inst_id_i[15:11];
            WB_ADDR_RT:   w_regw_addr_id = inst_id_i[20:16];
            WB_ADDR_LINK: w_regw_addr_id = REG_AW'(LINK_REG);
            default:      w_regw_addr_id = '0;
        endcase
    end

    assign w_ctrl_id = '{mem_ren:     mem_ren_i,
                         mem_wen:     mem_wen_i,
                         wb_data_src: wb_data_src_i,
                         wb_wen:      wb_wen_i & (w_regw_addr_id != '0)};

    assign w_exe_d = {pc_src_i, exe_a_src_i, exe_b_src_i, exe_alu_oper_i,
                      w_ctrl_id, w_regw_addr_id};

    pipe_ctrl_chain_stage_reg #(.W(1)) u_if_stage (
        .clk(clk), .rst(rst), .clr_i(if_rst_i), .en_i(if_en_i),
        .valid_i(1'b1), .data_i(1'b0),
        .valid_o(w_if_valid), .data_o(w_unused_if_pl)
    );

    pipe_ctrl_chain_stage_reg #(.W(1)) u_id_stage (
        .clk(clk), .rst(rst), .clr_i(id_rst_i), .en_i(id_en_i),
        .valid_i(w_if_valid), .data_i(1'b0),
        .valid_o(w_id_valid), .data_o(w_unused_id_pl)
    );

    pipe_ctrl_chain_stage_reg #(.W(EXE_W)) u_exe_stage (
        .clk(clk), .rst(rst), .clr_i(exe_rst_i), .en_i(exe_en_i),
        .valid_i(w_id_valid), .data_i(w_exe_d),
        .valid_o(w_exe_valid), .data_o(w_exe_q)
    );

    assign {pc_src_exe_o, exe_a_src_exe_o, exe_b_src_exe_o, exe_alu_oper_exe_o,
            w_ctrl_exe, regw_addr_exe_o} = w_exe_q;

    assign w_mem_d = {(pc_src_exe_o != '0), w_ctrl_exe, regw_addr_exe_o};

    pipe_ctrl_chain_stage_reg #(.W(MEM_W)) u_mem_stage (
        .clk(clk), .rst(rst), .clr_i(mem_rst_i), .en_i(mem_en_i),
        .valid_i(w_exe_valid), .data_i(w_mem_d),
        .valid_o(w_mem_valid), .data_o(w_mem_q)
    );

    assign {w_is_br_mem, w_ctrl_mem, regw_addr_mem_o} = w_mem_q;

    assign w_wb_d = {w_ctrl_mem.wb_data_src, w_ctrl_mem.wb_wen, regw_addr_mem_o};

    pipe_ctrl_chain_stage_reg #(.W(WB_W)) u_wb_stage (
        .clk(clk), .rst(rst), .clr_i(wb_rst_i), .en_i(wb_en_i),
        .valid_i(w_mem_valid), .data_i(w_wb_d),
        .valid_o(w_wb_valid), .data_o(w_wb_q)
    );

    assign wb_data_src_wb_o = w_wb_q[REG_AW+1];
    assign regw_addr_wb_o   = w_wb_q[REG_AW-1:0];

    // Only AND-gating with registered valids: no path from the strobes to any output.
    assign if_valid_o      = w_if_valid;
    assign id_valid_o      = w_id_valid;
    assign exe_valid_o     = w_exe_valid;
    assign mem_valid_o     = w_mem_valid;
    assign wb_valid_o      = w_wb_valid;
    assign is_branch_exe_o = w_exe_valid & (pc_src_exe_o != '0);
    assign wb_wen_exe_o    = w_exe_valid & w_ctrl_exe.wb_wen;
    assign mem_ren_mem_o   = w_mem_valid & w_ctrl_mem.mem_ren;
    assign mem_wen_mem_o   = w_mem_valid & w_ctrl_mem.mem_wen;
    assign is_branch_mem_o = w_mem_valid & w_is_br_mem;
    assign wb_wen_mem_o    = w_mem_valid & w_ctrl_mem.wb_wen;
    assign wb_wen_wb_o     = w_wb_valid & w_wb_q[REG_AW];

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_chain.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_ctrl_chain
// Brief  : Directed self-checking bench for pipe_ctrl_chain.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_rst_i, if_en_i, id_rst_i, id_en_i, exe_rst_i, exe_en_i;
    logic        mem_rst_i, mem_en_i, wb_rst_i, wb_en_i;
    logic [31:0] inst_id_i;
    logic [2:0]  pc_src_i;
    logic [1:0]  exe_a_src_i, exe_b_src_i, wb_addr_src_i;
    logic [3:0]  exe_alu_oper_i;
    logic        mem_ren_i, mem_wen_i, wb_data_src_i, wb_wen_i;
    logic        if_valid_o, id_valid_o, exe_valid_o, mem_valid_o, wb_valid_o;
    logic [2:0]  pc_src_exe_o;
    logic [1:0]  exe_a_src_exe_o, exe_b_src_exe_o;
    logic [3:0]  exe_alu_oper_exe_o;
    logic        is_branch_exe_o, wb_wen_exe_o;
    logic [4:0]  regw_addr_exe_o, regw_addr_mem_o, regw_addr_wb_o;
    logic        mem_ren_mem_o, mem_wen_mem_o, is_branch_mem_o, wb_wen_mem_o;
    logic        wb_data_src_wb_o, wb_wen_wb_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_chain #(.REG_AW(5), .LINK_REG(31), .PC_SRC_W(3)) dut (
        .clk(clk), .rst(rst),
        .if_rst_i(if_rst_i), .if_en_i(if_en_i),
        .id_rst_i(id_rst_i), .id_en_i(id_en_i),
        .exe_rst_i(exe_rst_i), .exe_en_i(exe_en_i),
        .mem_rst_i(mem_rst_i), .mem_en_i(mem_en_i),
        .wb_rst_i(wb_rst_i), .wb_en_i(wb_en_i),
        .inst_id_i(inst_id_i), .pc_src_i(pc_src_i),
        .exe_a_src_i(exe_a_src_i), .exe_b_src_i(exe_b_src_i),
        .exe_alu_oper_i(exe_alu_oper_i), .mem_ren_i(mem_ren_i),
        .mem_wen_i(mem_wen_i), .wb_addr_src_i(wb_addr_src_i),
        .wb_data_src_i(wb_data_src_i), .wb_wen_i(wb_wen_i),
        .if_valid_o(if_valid_o), .id_valid_o(id_valid_o),
        .exe_valid_o(exe_valid_o), .mem_valid_o(mem_valid_o),
        .wb_valid_o(wb_valid_o), .pc_src_exe_o(pc_src_exe_o),
        .exe_a_src_exe_o(exe_a_src_exe_o), .exe_b_src_exe_o(exe_b_src_exe_o),
        .exe_alu_oper_exe_o(exe_alu_oper_exe_o), .is_branch_exe_o(is_branch_exe_o),
        .regw_addr_exe_o(regw_addr_exe_o), .wb_wen_exe_o(wb_wen_exe_o),
        .mem_ren_mem_o(mem_ren_mem_o), .mem_wen_mem_o(mem_wen_mem_o),
        .is_branch_mem_o(is_branch_mem_o), .regw_addr_mem_o(regw_addr_mem_o),
        .wb_wen_mem_o(wb_wen_mem_o), .regw_addr_wb_o(regw_addr_wb_o),
        .wb_data_src_wb_o(wb_data_src_wb_o), .wb_wen_wb_o(wb_wen_wb_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_en(input logic i_f, input logic i_d, input logic e, input logic m, input logic w);
        if_en_i = i_f; id_en_i = i_d; exe_en_i = e; mem_en_i = m; wb_en_i = w;
    endtask

    task automatic set_bundle(input logic [2:0] pc, input logic [1:0] wsrc, input logic [31:0] inst,
                              input logic mren, input logic mwen, input logic wds, input logic wwen);
        pc_src_i = pc; wb_addr_src_i = wsrc; inst_id_i = inst;
        mem_ren_i = mren; mem_wen_i = mwen; wb_data_src_i = wds; wb_wen_i = wwen;
    endtask

    // rt=[20:16], rd=[15:11]
    localparam logic [31:0] INST_ADD3  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] INST_ADD7  = {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20};
    localparam logic [31:0] INST_JAL   = {6'h03, 26'h0000123};
    localparam logic [31:0] INST_LW5   = {6'h23, 5'd1, 5'd5, 16'h0004};
    localparam logic [31:0] INST_ADDI0 = {6'h08, 5'd1, 5'd0, 16'h0010};
    localparam logic [31:0] INST_SW    = {6'h2b, 5'd1, 5'd6, 16'h0008};

    initial begin
        rst = 1'b1;
        if_rst_i = 0; id_rst_i = 0; exe_rst_i = 0; mem_rst_i = 0; wb_rst_i = 0;
        set_en(0, 0, 0, 0, 0);
        exe_a_src_i = 2'd0; exe_b_src_i = 2'd0; exe_alu_oper_i = 4'd0;
        set_bundle(3'd0, 2'd0, 32'd0, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_if_valid", 32'(if_valid_o), 0);
        chk("rst_exe_valid", 32'(exe_valid_o), 0);
        chk("rst_wb_valid", 32'(wb_valid_o), 0);
        chk("rst_pc_src_exe", 32'(pc_src_exe_o), 0);
        chk("rst_regw_wb", 32'(regw_addr_wb_o), 0);

        // ADD rd=3 flowing with all enables
        rst = 1'b0;
        set_en(1, 1, 1, 1, 1);
        set_bundle(3'd0, 2'd0, INST_ADD3, 0, 0, 0, 1);
        exe_alu_oper_i = 4'd0;
        tick();
        chk("add_if_valid", 32'(if_valid_o), 1);
        tick();
        chk("add_exe_not_yet", 32'(exe_valid_o), 0);
        tick();
        chk("add_exe_valid", 32'(exe_valid_o), 1);
        chk("add_regw_exe", 32'(regw_addr_exe_o), 3);
        chk("add_wen_exe", 32'(wb_wen_exe_o), 1);
        tick();
        chk("add_regw_mem", 32'(regw_addr_mem_o), 3);
        chk("add_wen_mem", 32'(wb_wen_mem_o), 1);
        tick();
        chk("add_regw_wb", 32'(regw_addr_wb_o), 3);
        chk("add_wen_wb", 32'(wb_wen_wb_o), 1);

        // JAL enters EXE while ID is flushed for 3 cycles
        set_bundle(3'd2, 2'd2, INST_JAL, 0, 0, 0, 1);
        id_rst_i = 1'b1;
        tick();
        chk("jal_is_branch_exe", 32'(is_branch_exe_o), 1);
        chk("jal_regw_exe", 32'(regw_addr_exe_o), 31);
        chk("jal_id_flushed", 32'(id_valid_o), 0);
        set_bundle(3'd0, 2'd0, INST_ADD3, 0, 0, 0, 1);
        tick();
        chk("flush1_exe_valid", 32'(exe_valid_o), 0);
        chk("flush1_is_branch_exe", 32'(is_branch_exe_o), 0);
        chk("jal_is_branch_mem", 32'(is_branch_mem_o), 1);
        tick();
        chk("flush2_exe_valid", 32'(exe_valid_o), 0);
        id_rst_i = 1'b0;
        tick();
        chk("flush3_exe_valid", 32'(exe_valid_o), 0);
        chk("flush_id_refill", 32'(id_valid_o), 1);

        // LW rt=5 then 2 bubbles while a dependent ADD rd=7 waits in ID
        set_bundle(3'd0, 2'd1, INST_LW5, 1, 0, 1, 1);
        tick();
        chk("lw_regw_exe", 32'(regw_addr_exe_o), 5);
        chk("lw_wen_exe", 32'(wb_wen_exe_o), 1);
        set_bundle(3'd0, 2'd0, INST_ADD7, 0, 0, 0, 1);
        set_en(0, 0, 1, 1, 1);
        exe_rst_i = 1'b1;
        tick();
        chk("bub1_exe_valid", 32'(exe_valid_o), 0);
        chk("bub1_wen_exe", 32'(wb_wen_exe_o), 0);
        chk("bub1_mem_ren", 32'(mem_ren_mem_o), 1);
        chk("bub1_id_held", 32'(id_valid_o), 1);
        tick();
        chk("bub2_wen_exe", 32'(wb_wen_exe_o), 0);
        chk("bub2_mem_ren", 32'(mem_ren_mem_o), 0);
        exe_rst_i = 1'b0;
        set_en(1, 1, 1, 1, 1);
        tick();
        chk("reissue_exe_valid", 32'(exe_valid_o), 1);
        chk("reissue_regw_exe", 32'(regw_addr_exe_o), 7);

        // ADDI rt=0 never writes back
        set_bundle(3'd0, 2'd1, INST_ADDI0, 0, 0, 0, 1);
        tick();
        chk("addi0_exe_valid", 32'(exe_valid_o), 1);
        chk("addi0_wen_exe", 32'(wb_wen_exe_o), 0);
        tick();
        chk("addi0_wen_mem", 32'(wb_wen_mem_o), 0);
        tick();
        chk("addi0_wb_valid", 32'(wb_valid_o), 1);
        chk("addi0_wen_wb", 32'(wb_wen_wb_o), 0);

        // wb_addr_src=3 resolves to r0
        set_bundle(3'd0, 2'd3, INST_ADD3, 0, 0, 0, 1);
        tick();
        chk("src3_regw_exe", 32'(regw_addr_exe_o), 0);
        chk("src3_wen_exe", 32'(wb_wen_exe_o), 0);

        // SW reaches MEM, then global reset
        set_bundle(3'd0, 2'd0, INST_SW, 0, 1, 0, 0);
        tick();
        tick();
        chk("sw_mem_wen", 32'(mem_wen_mem_o), 1);
        rst = 1'b1;
        set_bundle(3'd0, 2'd0, INST_ADD3, 0, 0, 0, 1);
        tick();
        chk("rst_all_valids", 32'({if_valid_o, id_valid_o, exe_valid_o, mem_valid_o, wb_valid_o}), 0);
        chk("rst_mem_wen", 32'(mem_wen_mem_o), 0);
        chk("rst_regw_exe", 32'(regw_addr_exe_o), 0);
        chk("rst_wen_wb", 32'(wb_wen_wb_o), 0);
        rst = 1'b0;
        tick();
        chk("restart1_exe_valid", 32'(exe_valid_o), 0);
        tick();
        chk("restart2_exe_valid", 32'(exe_valid_o), 0);
        tick();
        chk("restart3_exe_valid", 32'(exe_valid_o), 1);

        // exe_rst beats exe_en
        exe_rst_i = 1'b1;
        tick();
        chk("rst_en_exe_valid", 32'(exe_valid_o), 0);
        chk("rst_en_wen_exe", 32'(wb_wen_exe_o), 0);
        chk("rst_en_id_valid", 32'(id_valid_o), 1);
        exe_rst_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
